// File: rtl/rns_convertor_iter.sv
// rtl/rns_convertor_iter.sv - iterative int<->RNS convertor for moduli {2^N-1, 2^N, 2^N+1}; define RNS_SAT_OVF_EN to saturate reverse overflow
module rns_convertor_iter #(
    parameter int N      = 22,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_int,
    input  logic [3*N:0]      in_rns,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [3*N:0]      out_rns,
    output logic [DATA_W-1:0] out_int,
    output logic              out_ovf
);
    localparam int K  = (DATA_W + N - 1) / N;
    localparam int KN = K * N;
    localparam int CW = $clog2(K + 1);
    localparam logic [N-1:0]   M0     = {N{1'b1}};
    localparam logic [N:0]     M2     = {1'b1, {(N-1){1'b0}}, 1'b1};
    localparam logic [3*N-1:0] M_VAL  = {{(2*N){1'b1}}, {N{1'b0}}};
    localparam logic [3*N-1:0] M_HALF = {1'b0, {(2*N){1'b1}}, {(N-1){1'b0}}};
`ifndef RNS_SAT_OVF_EN
    localparam logic [DATA_W-1:0] M_LO = M_VAL[DATA_W-1:0];
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FOLD, S_MRC1, S_MRC2, S_MRC3, S_FIX, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mode_q, mode_d;
    logic              neg_q, neg_d;
    logic [KN-1:0]     mag_q, mag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      acc0_q, acc0_d;
    logic [N:0]        acc2_q, acc2_d;
    logic [N-1:0]      r1_q, r1_d;
    logic [N:0]        b_q, b_d;
    logic [N-1:0]      c_q, c_d;
    logic [3*N-1:0]    x_q, x_d;
    logic              out_valid_q, out_valid_d;
    logic              out_mode_q, out_mode_d;
    logic [3*N:0]      out_rns_q, out_rns_d;
    logic [DATA_W-1:0] out_int_q, out_int_d;
`ifdef RNS_SAT_OVF_EN
    logic              out_ovf_q, out_ovf_d;
    logic [3*N:0]      s_val;
    logic [3*N-DATA_W+1:0] s_hi;
`endif

    logic [DATA_W-1:0] mag_in;
    logic [KN-1:0]     mag_full;
    logic [N-1:0]      cap_r0;
    logic [N:0]        cap_r2;
    logic [N-1:0]      chunk;
    logic [N+1:0]      sum2;
    logic [N-1:0]      bm, t_c, rot_c, fr0;
    logic [2*N-1:0]    hi_x;

    // one's-complement add: sum modulo 2^N-1 with end-around carry
    function automatic logic [N-1:0] eac_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[N-1:0] + {{(N-1){1'b0}}, s[N]};
    endfunction

    // next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        acc0_d      = acc0_q;
        acc2_d      = acc2_q;
        r1_d        = r1_q;
        b_d         = b_q;
        c_d         = c_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        out_mode_d  = out_mode_q;
        out_rns_d   = out_rns_q;
        out_int_d   = out_int_q;
`ifdef RNS_SAT_OVF_EN
        out_ovf_d   = out_ovf_q;
        s_val       = '0;
        s_hi        = '0;
`endif
        mag_in   = in_int[DATA_W-1] ? (~in_int + DATA_W'(1)) : in_int;
        mag_full = KN'(mag_in);
        cap_r0   = (in_rns[N-1:0] == M0) ? '0 : in_rns[N-1:0];
        cap_r2   = (in_rns[3*N:2*N] > M2) ? (in_rns[3*N:2*N] - M2) : in_rns[3*N:2*N];
        chunk    = mag_q[N-1:0];
        sum2     = '0;
        bm       = '0;
        t_c      = '0;
        rot_c    = '0;
        fr0      = (acc0_q == M0) ? '0 : acc0_q;
        hi_x     = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mode_d = in_mode;
                    cnt_d  = '0;
                    if (in_mode) begin
                        neg_d   = 1'b0;
                        acc0_d  = cap_r0;
                        r1_d    = in_rns[2*N-1:N];
                        acc2_d  = cap_r2;
                        state_d = S_MRC1;
                    end else begin
                        neg_d   = in_int[DATA_W-1];
                        mag_d   = mag_full;
                        r1_d    = mag_full[N-1:0];
                        acc0_d  = '0;
                        acc2_d  = '0;
                        state_d = S_FOLD;
                    end
                end
            end
            S_FOLD: begin
                acc0_d = eac_add(acc0_q, chunk);
                // 2^N == -1 mod 2^N+1, so odd chunks subtract
                if (cnt_q[0]) begin
                    sum2 = {1'b0, acc2_q} - {2'b0, chunk};
                    if (sum2[N+1]) sum2 = sum2 + {1'b0, M2};
                end else begin
                    sum2 = {1'b0, acc2_q} + {2'b0, chunk};
                    if (sum2 >= {1'b0, M2}) sum2 = sum2 - {1'b0, M2};
                end
                acc2_d = sum2[N:0];
                mag_d  = mag_q >> N;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) state_d = S_FIX;
            end
            S_MRC1: begin
                // b = (r1 - r2) mod 2^N+1, i.e. (r2 - r1) * (2^N)^-1
                sum2 = {2'b0, r1_q} - {1'b0, acc2_q};
                if (sum2[N+1]) sum2 = sum2 + {1'b0, M2};
                b_d     = sum2[N:0];
                state_d = S_MRC2;
            end
            S_MRC2: begin
                // c = (r0 - r1 - b) * 2^(N-1) mod 2^N-1; the multiply is a right rotate
                bm    = b_q[N-1:0] + {{(N-1){1'b0}}, b_q[N]};
                t_c   = eac_add(eac_add(acc0_q, ~r1_q), ~bm);
                rot_c = {t_c[0], t_c[N-1:1]};
                c_d   = (rot_c == M0) ? '0 : rot_c;
                state_d = S_MRC3;
            end
            S_MRC3: begin
                // X = r1 + 2^N * (b + c*(2^N+1)); the bracket is below 2^2N
                hi_x    = (2*N)'(b_q) + (2*N)'(c_q) + {c_q, {N{1'b0}}};
                x_d     = {hi_x, r1_q};
                state_d = S_FIX;
            end
            S_FIX: begin
                out_valid_d = 1'b1;
                out_mode_d  = mode_q;
                if (mode_q) begin
                    out_rns_d = '0;
`ifdef RNS_SAT_OVF_EN
                    s_val = (x_q >= M_HALF) ? ({1'b0, x_q} - {1'b0, M_VAL}) : {1'b0, x_q};
                    s_hi  = s_val[3*N:DATA_W-1];
                    if ((&s_hi) || !(|s_hi)) begin
                        out_int_d = s_val[DATA_W-1:0];
                        out_ovf_d = 1'b0;
                    end else begin
                        out_int_d = {s_val[3*N], {(DATA_W-1){~s_val[3*N]}}};
                        out_ovf_d = 1'b1;
                    end
`else
                    out_int_d = (x_q >= M_HALF) ? (x_q[DATA_W-1:0] - M_LO) : x_q[DATA_W-1:0];
`endif
                end else begin
                    out_int_d = '0;
`ifdef RNS_SAT_OVF_EN
                    out_ovf_d = 1'b0;
`endif
                    if (neg_q)
                        out_rns_d = {(acc2_q == '0) ? acc2_q : (M2 - acc2_q),
                                     -r1_q,
                                     (fr0 == '0) ? fr0 : (M0 - fr0)};
                    else
                        out_rns_d = {acc2_q, r1_q, fr0};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mode_q      <= 1'b0;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            acc0_q      <= '0;
            acc2_q      <= '0;
            r1_q        <= '0;
            b_q         <= '0;
            c_q         <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_rns_q   <= '0;
            out_int_q   <= '0;
`ifdef RNS_SAT_OVF_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mode_q      <= mode_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            acc0_q      <= acc0_d;
            acc2_q      <= acc2_d;
            r1_q        <= r1_d;
            b_q         <= b_d;
            c_q         <= c_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
            out_rns_q   <= out_rns_d;
            out_int_q   <= out_int_d;
`ifdef RNS_SAT_OVF_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign out_rns   = out_rns_q;
    assign out_int   = out_int_q;
`ifdef RNS_SAT_OVF_EN
    assign out_ovf   = out_ovf_q;
`else
    assign out_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_rns_convertor_iter.sv
// tb/tb_rns_convertor_iter.sv - directed and round-trip bench for rns_convertor_iter
module tb_rns_convertor_iter;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_int;
    logic [66:0] in_rns;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode;
    logic [66:0] out_rns;
    logic [63:0] out_int;
    logic        out_ovf;

    int n_checks;
    int n_fails;

    rns_convertor_iter #(.N(22), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_int(in_int), .in_rns(in_rns),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_rns(out_rns), .out_int(out_int), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] pk(input logic [22:0] r2, input logic [21:0] r1, input logic [21:0] r0);
        return {r2, r1, r0};
    endfunction

    // one request through the full handshake; outputs held hold cycles before out_ready
    task automatic run_req(input logic mode, input logic [63:0] xi, input logic [66:0] ri, input int hold,
                           output logic [66:0] orns, output logic [63:0] oint, output logic oovf,
                           output logic omode, output int lat);
        int   guard;
        logic busy_rdy;
        logic stable;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("ready_before_req", in_ready, 1);
        in_valid = 1; in_mode = mode; in_int = xi; in_rns = ri;
        @(posedge clk); #1;
        in_mode = ~mode; in_int = ~xi; in_rns = ~ri;
        lat = 0;
        busy_rdy = 0;
        while (!out_valid && lat < 20) begin
            busy_rdy |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 0;
        check_eq("out_valid_seen", out_valid, 1);
        orns = out_rns; oint = out_int; oovf = out_ovf; omode = out_mode;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            busy_rdy |= in_ready;
            @(posedge clk); #1;
            if (!out_valid || out_rns !== orns || out_int !== oint || out_ovf !== oovf || out_mode !== omode)
                stable = 0;
        end
        busy_rdy |= in_ready;
        check_eq("busy_in_ready_low", busy_rdy, 0);
        if (hold > 0) check_eq("hold_stable", stable, 1);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check_eq("post_hs_out_valid", out_valid, 0);
        check_eq("post_hs_in_ready", in_ready, 1);
    endtask

    task automatic fwd_chk(input string tag, input logic [63:0] x, input logic [66:0] exp_rns, input int hold);
        logic [66:0] r; logic [63:0] v; logic o; logic m; int lat;
        run_req(1'b0, x, '0, hold, r, v, o, m, lat);
        check_eq({tag, "_rns"}, r, exp_rns);
        check_eq({tag, "_int0"}, v, 0);
        check_eq({tag, "_ovf0"}, o, 0);
        check_eq({tag, "_mode"}, m, 0);
        check_eq({tag, "_lat"}, lat, 4);
    endtask

    task automatic rev_chk(input string tag, input logic [66:0] rns, input logic [63:0] exp_int, input logic exp_ovf);
        logic [66:0] r; logic [63:0] v; logic o; logic m; int lat;
        run_req(1'b1, '0, rns, 0, r, v, o, m, lat);
        check_eq({tag, "_int"}, v, exp_int);
        check_eq({tag, "_ovf"}, o, exp_ovf);
        check_eq({tag, "_rns0"}, r, 0);
        check_eq({tag, "_mode"}, m, 1);
        check_eq({tag, "_lat"}, lat, 4);
    endtask

    task automatic round_trip(input string tag, input logic [63:0] x);
        logic [66:0] r; logic [66:0] r2; logic [63:0] v; logic o; logic m; int lat;
        run_req(1'b0, x, '0, 0, r, v, o, m, lat);
        run_req(1'b1, '0, r, 0, r2, v, o, m, lat);
        check_eq({tag, "_int"}, v, x);
        check_eq({tag, "_ovf"}, o, 0);
        check_eq({tag, "_lat"}, lat, 4);
    endtask

    initial begin
        logic [63:0] x;
        int guard;
        n_checks = 0; n_fails = 0;
        clk = 0; reset = 1; in_valid = 0; in_mode = 0; in_int = 0; in_rns = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_mode", out_mode, 0);
        check_eq("rst_out_rns", out_rns, 0);
        check_eq("rst_out_int", out_int, 0);
        check_eq("rst_out_ovf", out_ovf, 0);
        reset = 0;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", in_ready, 1);

        fwd_chk("fwd_zero", 64'd0, pk(0, 0, 0), 0);
        fwd_chk("fwd_five", 64'd5, pk(5, 5, 5), 0);
        fwd_chk("fwd_m1", 64'hFFFF_FFFF_FFFF_FFFF, pk(23'h400000, 22'h3FFFFF, 22'h3FFFFE), 0);
        fwd_chk("fwd_m5", -64'sd5, pk(23'h3FFFFC, 22'h3FFFFB, 22'h3FFFFA), 0);
        fwd_chk("fwd_2p22", 64'h40_0000, pk(23'h400000, 0, 1), 0);
        fwd_chk("fwd_max", 64'h7FFF_FFFF_FFFF_FFFF, pk(23'h7FFFF, 22'h3FFFFF, 22'h7FFFF), 0);
        fwd_chk("fwd_min", 64'h8000_0000_0000_0000, pk(23'h380001, 0, 22'h37FFFF), 10);

        rev_chk("rev_five", pk(5, 5, 5), 64'd5, 0);
        rev_chk("rev_m1", pk(23'h400000, 22'h3FFFFF, 22'h3FFFFE), 64'hFFFF_FFFF_FFFF_FFFF, 0);
        rev_chk("rev_2p22", pk(23'h400000, 0, 1), 64'h40_0000, 0);
        rev_chk("rev_alt0_r0", pk(0, 0, 22'h3FFFFF), 64'd0, 0);
        rev_chk("rev_alt0_r2", pk(23'h400001, 0, 0), 64'd0, 0);
`ifdef RNS_SAT_OVF_EN
        rev_chk("rev_2p63", pk(23'h80000, 0, 22'h80000), 64'h7FFF_FFFF_FFFF_FFFF, 1);
`else
        rev_chk("rev_2p63", pk(23'h80000, 0, 22'h80000), 64'h8000_0000_0000_0000, 0);
`endif

        round_trip("rt_max", 64'h7FFF_FFFF_FFFF_FFFF);
        round_trip("rt_min", 64'h8000_0000_0000_0000);
        round_trip("rt_neg", -64'sd65966565776878);

        // reset pulse while folding
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1; in_mode = 0; in_int = 64'd12345;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_out_rns", out_rns, 0);
        @(posedge clk); #1;
        check_eq("midrst_in_ready_back", in_ready, 1);
        fwd_chk("midrst_fresh", 64'd5, pk(5, 5, 5), 0);

        for (int i = 0; i < 1000; i++) begin
            x = {$urandom(), $urandom()};
            if (i % 4 == 1) x = 64'($urandom_range(0, 1000));
            if (i % 4 == 2) x = -64'($urandom_range(0, 1000));
            round_trip("rt_rand", x);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
